// File: rtl/fetch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_pkg : jump kinds and sequential PC step for the fetch stage
// Revision  : 1.0
// ------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    NEAR     = 2'd0,
    FAR      = 2'd1,
    RELATIVE = 2'd2,
    RETURN   = 2'd3
  } jump_kind_t;

  localparam int PC_STEP = 4;

endpackage
`default_nettype wire

// File: rtl/return_address_stack.sv
`default_nettype none
// ------------------------------------------------------------------
// return_address_stack : circular return-address stack with saturating count
// Revision             : 1.0
// ------------------------------------------------------------------
module return_address_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] pushValue,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  entries [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_up;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             swap;

  // ptr always addresses the current top entry
  assign ptr_up = ptr + 1'b1;
  assign top    = entries[ptr];
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_CNT);
  assign do_pop = pop && !empty;
  assign swap   = push && do_pop;

  always_ff @(posedge clock) begin
    if (swap) begin
      entries[ptr] <= pushValue;
    end else if (push) begin
      entries[ptr_up] <= pushValue;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (swap) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      // a push on a full stack wraps onto the oldest entry
      ptr <= ptr_up;
      if (!full) begin
        count <= count + 1'b1;
      end
    end else if (do_pop) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_pc_unit : fetch PC with prioritised redirect channels and RAS
// Revision      : 1.0
// ------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00003000,
  parameter int              NUM_REDIRECT = 2,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 stall,
  input  logic [NUM_REDIRECT-1:0]              redirectValid,
  input  logic [NUM_REDIRECT-1:0][1:0]         redirectType,
  input  logic [NUM_REDIRECT-1:0][XLEN-1:0]    redirectBase,
  input  logic [NUM_REDIRECT-1:0][XLEN-1:0]    redirectOperand,
  input  logic                                 pushValid,
  input  logic [XLEN-1:0]                      pushValue,
  output logic [XLEN-1:0]                      value,
  output logic [NUM_REDIRECT-1:0]              redirectTaken,
  output logic                                 rasEmpty,
  output logic                                 rasUnderflow
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [NUM_REDIRECT-1:0] grant;
  logic                    granted;
  jump_kind_t              kind;
  logic [XLEN-1:0]         base;
  logic [XLEN-1:0]         operand;
  logic [XLEN-1:0]         seq_pc;
  logic [XLEN-1:0]         target;
  logic [XLEN-1:0]         next_value;
  logic [XLEN-1:0]         ras_top;
  logic                    ras_empty;
  logic                    ras_full;
  logic                    update;
  logic                    is_return;
  logic                    ras_push;
  logic                    ras_pop;

  // Walk from the highest index down so the lowest valid channel wins
  always_comb begin
    grant   = '0;
    granted = 1'b0;
    kind    = NEAR;
    base    = '0;
    operand = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (redirectValid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        granted  = 1'b1;
        kind     = jump_kind_t'(redirectType[i]);
        base     = redirectBase[i];
        operand  = redirectOperand[i];
      end
    end
  end

  assign seq_pc = value + STEP;

  always_comb begin
    target = seq_pc;
    unique case (kind)
      NEAR:     target = {base[XLEN-1:XLEN-4], operand[XLEN-7:0], 2'b00};
      FAR:      target = operand;
      RELATIVE: target = base + {operand[XLEN-3:0], 2'b00};
      RETURN:   target = ras_empty ? seq_pc : ras_top;
    endcase
  end

  assign update     = granted || !stall;
  assign is_return  = granted && (kind == RETURN);
  assign ras_pop    = update && is_return && !ras_empty;
  assign ras_push   = update && pushValid;
  assign next_value = granted ? target : (stall ? value : seq_pc);
  assign rasEmpty   = ras_empty;

  return_address_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pushValue (pushValue),
    .pop       (ras_pop),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      value         <= RESET_VECTOR;
      redirectTaken <= '0;
      rasUnderflow  <= 1'b0;
    end else begin
      value         <= next_value;
      redirectTaken <= grant;
      rasUnderflow  <= is_return && ras_empty;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (update) begin
        $display("[fetch_pc] %h -> %h%s", value, next_value,
                 (ras_push && ras_full && !ras_pop) ? " (ras overwrite)" : "");
      end else begin
        $display("[fetch_pc] stall at %h", value);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised program counter for the fetch stage, successor to the single-redirect PC. It holds the fetch address, advances it sequentially, and arbitrates between `NUM_REDIRECT` prioritised redirect channels (NEAR / FAR / RELATIVE / RETURN). An internal return-address stack (RAS) serves RETURN redirects. It sits at the head of the pipeline, between the hazard unit (stall) and the decode/execute redirect sources.

## Interface
- `XLEN`, 32: address width; must be at least 8.
- `RESET_VECTOR`, 32'h00003000: value of `value` after reset.
- `NUM_REDIRECT`, 2: number of redirect channels; channel 0 has highest priority.
- `RAS_DEPTH`, 4: number of RAS entries; must be a power of 2 and at least 2.

- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold PC; overridden by any redirect.
- `redirectValid`  in  NUM_REDIRECT  per-channel redirect request.
- `redirectType`  in  NUM_REDIRECT×2  per-channel `jump_kind_t`.
- `redirectBase`  in  NUM_REDIRECT×XLEN  per-channel base address; the caller supplies its own pc+4.
- `redirectOperand`  in  NUM_REDIRECT×XLEN  per-channel operand x.
- `pushValid`  in  1  push `pushValue` onto the RAS (call instruction).
- `pushValue`  in  XLEN  return address to push.
- `value`  out  XLEN  current fetch PC; reset value `RESET_VECTOR`.
- `redirectTaken`  out  NUM_REDIRECT  one-hot grant registered with the update; reset value 0.
- `rasEmpty`  out  1  RAS count is 0; reset value 1.
- `rasUnderflow`  out  1  one-cycle pulse: a RETURN was granted while the RAS was empty; reset value 0.

## Operation
- Arbitration: the lowest-index channel with `redirectValid` set wins. The other channels are ignored for that cycle.
- Target of the winning channel, with base b and operand x:
  - NEAR: `{b[XLEN-1:XLEN-4], x[XLEN-7:0], 2'b00}`.
  - FAR: `x`.
  - RELATIVE: `b + (x << 2)`, truncated to XLEN bits; wraps modulo 2^XLEN.
  - RETURN: the RAS top entry. If the RAS is empty, the target is `value + 4` and `rasUnderflow` pulses.
- Next value:
  - Redirect granted: the target.
  - Else if `stall`: `value` (hold).
  - Else: `value + 4`, wrapping modulo 2^XLEN.
- `update` = (redirect granted) OR (NOT `stall`). RAS operations occur only in cycles where `update` is true.
- RAS bookkeeping:
  - Circular buffer with a top pointer and a count in the range 0..RAS_DEPTH.
  - Pop: occurs when the granted channel is RETURN and count > 0. Decrements the count.
  - Push: occurs when `pushValid` is set. Writes `pushValue`, advances the pointer and increments the count, saturating at RAS_DEPTH.
  - Push on a full RAS: overwrites the oldest entry; the count stays at RAS_DEPTH.
  - Push and pop in the same cycle: the popped target is the old top; `pushValue` replaces it; the pointer and count are unchanged.
- Reset: `value` = RESET_VECTOR, RAS count = 0, pointer = 0, all outputs at their reset values. Reset overrides every other input, including mid-stall and mid-redirect.

## Timing
- All state updates on posedge `clock`. The target computation and arbitration are combinational from the inputs in the same cycle.
- Redirect latency is 1: a target presented in cycle n appears on `value` in cycle n+1.
- `redirectTaken` and `rasUnderflow` are registered. They describe the update that produced the current `value`.
- First cycle after reset deasserts: `value` = RESET_VECTOR. The following cycle shows RESET_VECTOR+4 if there is no stall.
- No back-pressure; every redirect is accepted in the cycle it is presented.

## Structure
- Shared package `fetch_pkg`:
  - `jump_kind_t` with values NEAR = 0, FAR = 1, RELATIVE = 2, RETURN = 3. This supersedes `jump_type_t`.
  - Constant `PC_STEP` = 4.
- Sub-module `return_address_stack`, parametrised by XLEN and RAS_DEPTH. Ports: push, pushValue, pop, top, empty, full.
- Retain the per-cycle debug `$display` of the PC change/stall, wrapped in a simulation-only guard.

## Test plan
- Reset release → `value` = 0x3000, then 0x3004, then 0x3008; `rasEmpty` = 1.
- `stall` held 3 cycles at 0x3008 → `value` stays 0x3008. A FAR redirect to 0x4000 asserted during the stall → `value` = 0x4000 next cycle and `redirectTaken` = 2'b01 (channel 0 granted).
- Channel 0 RELATIVE (b = 0x3010, x = 0xFFFFFFFC) and channel 1 FAR (0x9000) in the same cycle → `value` = 0x3000 and `redirectTaken` = 2'b01.
- NEAR with b = 0x30000010, x = 0x100 → `value` = 0x30000400.
- Push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 (RAS_DEPTH = 4), then five RETURNs:
  - First four RETURNs → 0xE0, 0xD0, 0xC0, 0xB0.
  - Fifth RETURN → `value` = previous `value` + 4 with `rasUnderflow` pulsed.
- Push 0x50 and RETURN in the same cycle with top = 0x40 → `value` = 0x40, new top = 0x50, count unchanged.
- Assert `reset` mid-stall with RAS count 3 → `value` = 0x3000 and `rasEmpty` = 1 on the next cycle.
